ring_counter_param: RTL and testbench

- Parametrised ring/Johnson counter. Generalises the fixed 4-bit ring counter to any width.
- Adds runtime mode select (ring or Johnson), shift direction, synchronous seed load and count enable.
- Adds a step-position counter, a full-period wrap pulse, and illegal-state detection with optional self-correction.
- Used as a one-hot/Johnson sequencer for phase generation and round-robin selection.

---
 rtl/ring_counter_param.sv | 97 +++++++++
 tb/tb_ring_counter_param.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ring_counter_param.sv
// Parametrised ring / Johnson sequencer with step position, wrap pulse
// and illegal-state detection with optional self-correction.
module ring_counter_param #(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] RESET_VAL    = WIDTH'(1),
    parameter bit               SELF_CORRECT = 1'b1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        en,
    input  logic                        load,
    input  logic [WIDTH-1:0]            seed,
    input  logic                        mode,
    input  logic                        dir,
    output logic [WIDTH-1:0]            out,
    output logic [$clog2(2*WIDTH)-1:0]  pos,
    output logic                        wrap,
    output logic                        illegal
);

    localparam int PW = $clog2(2*WIDTH);

    if (WIDTH < 2) begin : g_bad_width
        $error("ring_counter_param: WIDTH must be >= 2");
    end

    logic [WIDTH-1:0] out_q, out_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] step_val;
    logic [PW-1:0]    pos_last;
    int               ones;
    int               edges;

    // Ring needs exactly one hot bit; Johnson allows at most one 0/1 boundary.
    always_comb begin
        ones  = 0;
        edges = 0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + int'(out_q[i]);
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            edges = edges + int'(out_q[i] ^ out_q[i+1]);
        end
        illegal = mode ? (edges > 1) : (ones != 1);
    end

    always_comb begin
        unique case ({mode, dir})
            2'b00:   step_val = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
            2'b01:   step_val = {out_q[0], out_q[WIDTH-1:1]};
            2'b10:   step_val = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
            default: step_val = {~out_q[0], out_q[WIDTH-1:1]};
        endcase
    end

    assign pos_last = mode ? PW'(2*WIDTH - 1) : PW'(WIDTH - 1);

    always_comb begin
        out_d  = out_q;
        pos_d  = pos_q;
        wrap_d = 1'b0;
        if (load) begin
            out_d = seed;
            pos_d = '0;
        end else if (en && illegal && SELF_CORRECT) begin
            out_d = RESET_VAL;
            pos_d = '0;
        end else if (en) begin
            out_d = step_val;
            // >= also recovers a pos left high by a Johnson->ring switch
            if (pos_q >= pos_last) begin
                pos_d  = '0;
                wrap_d = 1'b1;
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            out_q  <= RESET_VAL;
            pos_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            pos_q  <= pos_d;
            wrap_q <= wrap_d;
        end
    end

    assign out  = out_q;
    assign pos  = pos_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_ring_counter_param.sv
// Scoreboard bench for ring_counter_param, WIDTH=4, with a
// self-correcting and a non-correcting instance sharing stimulus.
module tb_ring_counter_param;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic       load;
    logic [3:0] seed;
    logic       mode;
    logic       dir;
    logic [3:0] out, out_nc;
    logic [2:0] pos, pos_nc;
    logic       wrap, wrap_nc;
    logic       illegal, illegal_nc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic [3:0] o;
        int         p;
        bit         w;
        bit         il;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ring_counter_param #(.WIDTH(4), .RESET_VAL(4'b0001), .SELF_CORRECT(1'b1)) dut (
        .clk(clk), .rstn(rstn), .en(en), .load(load), .seed(seed),
        .mode(mode), .dir(dir), .out(out), .pos(pos), .wrap(wrap),
        .illegal(illegal)
    );

    ring_counter_param #(.WIDTH(4), .RESET_VAL(4'b0001), .SELF_CORRECT(1'b0)) dut_nc (
        .clk(clk), .rstn(rstn), .en(en), .load(load), .seed(seed),
        .mode(mode), .dir(dir), .out(out_nc), .pos(pos_nc), .wrap(wrap_nc),
        .illegal(illegal_nc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input bit e_, input bit l_,
                        input logic [3:0] s_, input logic [3:0] eo,
                        input int ep, input bit ew, input bit eil);
        exp_t x;
        exp_t y;
        en   = e_;
        load = l_;
        seed = s_;
        x.tag = tag;
        x.o   = eo;
        x.p   = ep;
        x.w   = ew;
        x.il  = eil;
        sb.push_back(x);
        @(posedge clk);
        #1;
        y = sb.pop_front();
        chk({y.tag, ".out"}, 32'(out), 32'(y.o));
        chk({y.tag, ".pos"}, 32'(pos), 32'(y.p));
        chk({y.tag, ".wrap"}, 32'(wrap), 32'(y.w));
        chk({y.tag, ".ill"}, 32'(illegal), 32'(y.il));
        en   = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        rstn = 1'b1;
        en   = 1'b0;
        load = 1'b0;
        seed = 4'b0000;
        mode = 1'b0;
        dir  = 1'b0;
        #7;
        chk("rst.out", 32'(out), 32'h1);
        chk("rst.pos", 32'(pos), 32'h0);
        chk("rst.wrap", 32'(wrap), 32'h0);
        chk("rst.ill", 32'(illegal), 32'h0);
        rstn = 1'b0;

        // async reset from 0100 between edges
        step("t1a", 1, 0, 4'b0000, 4'b0010, 1, 0, 0);
        step("t1b", 1, 0, 4'b0000, 4'b0100, 2, 0, 0);
        #2 rstn = 1'b1;
        #1;
        chk("t1.out", 32'(out), 32'h1);
        chk("t1.pos", 32'(pos), 32'h0);
        chk("t1.wrap", 32'(wrap), 32'h0);
        #1 rstn = 1'b0;

        // ring, dir=0
        step("t2a", 1, 0, 4'b0000, 4'b0010, 1, 0, 0);
        step("t2b", 1, 0, 4'b0000, 4'b0100, 2, 0, 0);
        step("t2c", 1, 0, 4'b0000, 4'b1000, 3, 0, 0);
        step("t2d", 1, 0, 4'b0000, 4'b0001, 0, 1, 0);

        // Johnson, dir=0 then dir=1
        mode = 1'b1;
        step("t3ld", 0, 1, 4'b0000, 4'b0000, 0, 0, 0);
        step("t3a", 1, 0, 4'b0000, 4'b0001, 1, 0, 0);
        step("t3b", 1, 0, 4'b0000, 4'b0011, 2, 0, 0);
        step("t3c", 1, 0, 4'b0000, 4'b0111, 3, 0, 0);
        step("t3d", 1, 0, 4'b0000, 4'b1111, 4, 0, 0);
        step("t3e", 1, 0, 4'b0000, 4'b1110, 5, 0, 0);
        step("t3f", 1, 0, 4'b0000, 4'b1100, 6, 0, 0);
        step("t3g", 1, 0, 4'b0000, 4'b1000, 7, 0, 0);
        step("t3h", 1, 0, 4'b0000, 4'b0000, 0, 1, 0);
        dir = 1'b1;
        step("t3i", 1, 0, 4'b0000, 4'b1000, 1, 0, 0);
        step("t3j", 1, 0, 4'b0000, 4'b1100, 2, 0, 0);
        step("t3k", 1, 0, 4'b0000, 4'b1110, 3, 0, 0);
        step("t3l", 1, 0, 4'b0000, 4'b1111, 4, 0, 0);
        step("t3m", 1, 0, 4'b0000, 4'b0111, 5, 0, 0);
        step("t3n", 1, 0, 4'b0000, 4'b0011, 6, 0, 0);
        step("t3o", 1, 0, 4'b0000, 4'b0001, 7, 0, 0);
        step("t3p", 1, 0, 4'b0000, 4'b0000, 0, 1, 0);

        // illegal seed, with and without self-correction
        mode = 1'b0;
        step("t4ld", 0, 1, 4'b1011, 4'b1011, 0, 0, 1);
        chk("t4.nc.ill0", 32'(illegal_nc), 32'h1);
        step("t4fix", 1, 0, 4'b0000, 4'b0001, 0, 0, 0);
        chk("t4.nc.out", 32'(out_nc), 32'hd);
        chk("t4.nc.ill", 32'(illegal_nc), 32'h1);

        // load beats en, then hold
        dir = 1'b0;
        step("t5ld", 1, 1, 4'b0100, 4'b0100, 0, 0, 0);
        step("t5s", 1, 0, 4'b0000, 4'b1000, 1, 0, 0);
        step("t5h1", 0, 0, 4'b0000, 4'b1000, 1, 0, 0);
        step("t5h2", 0, 0, 4'b0000, 4'b1000, 1, 0, 0);
        step("t5h3", 0, 0, 4'b0000, 4'b1000, 1, 0, 0);

        // Johnson 1100 at pos 5, then switch to ring
        mode = 1'b1;
        dir  = 1'b1;
        step("t6ld", 0, 1, 4'b0111, 4'b0111, 0, 0, 0);
        step("t6a", 1, 0, 4'b0000, 4'b0011, 1, 0, 0);
        step("t6b", 1, 0, 4'b0000, 4'b0001, 2, 0, 0);
        step("t6c", 1, 0, 4'b0000, 4'b0000, 3, 0, 0);
        step("t6d", 1, 0, 4'b0000, 4'b1000, 4, 0, 0);
        step("t6e", 1, 0, 4'b0000, 4'b1100, 5, 0, 0);
        mode = 1'b0;
        #1;
        chk("t6.ill", 32'(illegal), 32'h1);
        step("t6fix", 1, 0, 4'b0000, 4'b0001, 0, 0, 0);
        step("t6f", 1, 0, 4'b0000, 4'b1000, 1, 0, 0);
        step("t6g", 1, 0, 4'b0000, 4'b0100, 2, 0, 0);
        step("t6h", 1, 0, 4'b0000, 4'b0010, 3, 0, 0);
        step("t6i", 1, 0, 4'b0000, 4'b0001, 0, 1, 0);

        // legal state with pos above ring P-1 after switch
        mode = 1'b1;
        step("t7ld", 0, 1, 4'b0000, 4'b0000, 0, 0, 0);
        step("t7a", 1, 0, 4'b0000, 4'b1000, 1, 0, 0);
        step("t7b", 1, 0, 4'b0000, 4'b1100, 2, 0, 0);
        step("t7c", 1, 0, 4'b0000, 4'b1110, 3, 0, 0);
        step("t7d", 1, 0, 4'b0000, 4'b1111, 4, 0, 0);
        step("t7e", 1, 0, 4'b0000, 4'b0111, 5, 0, 0);
        step("t7f", 1, 0, 4'b0000, 4'b0011, 6, 0, 0);
        step("t7g", 1, 0, 4'b0000, 4'b0001, 7, 0, 0);
        mode = 1'b0;
        dir  = 1'b0;
        step("t7h", 1, 0, 4'b0000, 4'b0010, 0, 1, 0);
        step("t7i", 0, 0, 4'b0000, 4'b0010, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
